// File: rtl/frigate_xo_sequencer.sv
// ----------------------------------------------------------------------------
// frigate_xo_sequencer
//
// Start-up and supervision controller for one crystal oscillator (LSXO or
// HSXO). It enables the oscillator and waits a fixed start-up time. It then
// qualifies the returned clock by counting its rising edges in a window of
// the always-on reference clock. After that it watches for lost edges while
// running, parks the oscillator in standby on request, and retries a bounded
// number of times before it flags failure.
//
// State table:
//   state | meaning
//   OFF   | oscillator disabled, all counters and retry count cleared
//   START | xo_ena=1, waiting STARTUP_CYCLES for the crystal to build up
//   CHECK | xo_ena=1, counting xo_dout edges over a CHECK_CYCLES window
//   RUN   | clock qualified (clk_ok=1), edge-gap watchdog active
//   STBY  | xo_ena=1 and xo_standby=1, watchdog idle, requalify on exit
//   FAIL  | retries exhausted, oscillator off, fail=1 until req_on drops
//
// Ports:
//   clk         always-on RC reference clock (only clock)
//   reset       synchronous, active-high
//   req_on      software request to run the oscillator (level)
//   sleep_req   request to park a running oscillator in standby (level)
//   xo_dout     oscillator output, asynchronous to clk, <= clk/4
//   xo_ena      oscillator enable
//   xo_standby  oscillator standby
//   clk_ok      oscillator qualified and running
//   fail        retries exhausted (sticky until req_on=0)
//   state       current state encoding for status readback
//   retry_cnt   failed qualifications since last OFF or pass (saturating)
// ----------------------------------------------------------------------------
module frigate_xo_sequencer #(
    parameter int STARTUP_CYCLES = 16384,
    parameter int CHECK_CYCLES   = 256,
    parameter int MIN_EDGES      = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_on,
    input  logic       sleep_req,
    input  logic       xo_dout,
    output logic       xo_ena,
    output logic       xo_standby,
    output logic       clk_ok,
    output logic       fail,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int CW = $clog2(CHECK_CYCLES + 1);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] WIN_LAST   = CW'(CHECK_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_MIN   = EW'(MIN_EDGES);
    localparam logic [WW-1:0] WD_LOAD    = WW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_START = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_STBY  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;

    logic            dout_sync1;
    logic            dout_sync2;
    logic            dout_hist;
    logic            xo_edge;

    logic [SW-1:0]   start_cnt;
    logic [CW-1:0]   win_cnt;
    logic [EW-1:0]   edge_cnt;
    logic [EW-1:0]   edge_cnt_nxt;
    logic [WW-1:0]   wd_cnt;
    logic [RW-1:0]   retry_r;
    logic [RW-1:0]   retry_nxt;
    logic [RW-1:0]   retry_inc;
    logic            retry_exhausted;
    logic            qual_pass;

    // ------------------------------------------------------------------
    // xo_dout synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_sync1 <= 1'b0;
            dout_sync2 <= 1'b0;
            dout_hist  <= 1'b0;
        end else begin
            dout_sync1 <= xo_dout;
            dout_sync2 <= dout_sync1;
            dout_hist  <= dout_sync2;
        end
    end

    assign xo_edge = dout_sync2 & ~dout_hist;

    // ------------------------------------------------------------------
    // Qualification helpers
    // ------------------------------------------------------------------
    // The edge seen in the final window cycle still counts toward the pass.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        if (xo_edge && (edge_cnt != EDGE_MIN)) begin
            edge_cnt_nxt = edge_cnt + EW'(1);
        end
    end

    assign qual_pass = (edge_cnt_nxt == EDGE_MIN);

    always_comb begin
        retry_inc = retry_r;
        if (retry_r != RETRY_MAX) begin
            retry_inc = retry_r + RW'(1);
        end
    end

    // New retry count above MAX_RETRIES-1 means no attempts are left.
    assign retry_exhausted = (retry_inc >= RETRY_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        retry_nxt = retry_r;

        case (cur_state)
            S_OFF: begin
                retry_nxt = '0;
                if (req_on) begin
                    nxt_state = S_START;
                end
            end

            S_START: begin
                if (start_cnt == START_LAST) begin
                    nxt_state = S_CHECK;
                end
            end

            S_CHECK: begin
                if (win_cnt == WIN_LAST) begin
                    if (qual_pass) begin
                        nxt_state = S_RUN;
                        retry_nxt = '0;
                    end else begin
                        retry_nxt = retry_inc;
                        nxt_state = retry_exhausted ? S_FAIL : S_START;
                    end
                end
            end

            S_RUN: begin
                // Sleep wins over an expiring watchdog; a fresh edge
                // reloads the watchdog instead of letting it expire.
                if (sleep_req) begin
                    nxt_state = S_STBY;
                end else if ((wd_cnt == '0) && !xo_edge) begin
                    retry_nxt = retry_inc;
                    nxt_state = retry_exhausted ? S_FAIL : S_CHECK;
                end
            end

            S_STBY: begin
                if (!sleep_req) begin
                    nxt_state = S_CHECK;
                end
            end

            S_FAIL: begin
                nxt_state = S_FAIL;
            end

            default: begin
                nxt_state = S_OFF;
            end
        endcase

        if (!req_on) begin
            nxt_state = S_OFF;
            retry_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // State register, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_OFF;
            start_cnt  <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            wd_cnt     <= '0;
            retry_r    <= '0;
            xo_ena     <= 1'b0;
            xo_standby <= 1'b0;
            clk_ok     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            retry_r   <= retry_nxt;

            // Each counter restarts from zero on every entry to its state.
            if ((cur_state == S_START) && (nxt_state == S_START)) begin
                start_cnt <= start_cnt + SW'(1);
            end else begin
                start_cnt <= '0;
            end

            if ((cur_state == S_CHECK) && (nxt_state == S_CHECK)) begin
                win_cnt  <= win_cnt + CW'(1);
                edge_cnt <= edge_cnt_nxt;
            end else begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end

            if (nxt_state != S_RUN) begin
                wd_cnt <= '0;
            end else if ((cur_state != S_RUN) || xo_edge) begin
                wd_cnt <= WD_LOAD;
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - WW'(1);
            end

            xo_ena     <= (nxt_state == S_START) || (nxt_state == S_CHECK) ||
                          (nxt_state == S_RUN)   || (nxt_state == S_STBY);
            xo_standby <= (nxt_state == S_STBY);
            clk_ok     <= (nxt_state == S_RUN);
            fail       <= (nxt_state == S_FAIL);
        end
    end

    assign state     = cur_state;
    assign retry_cnt = 2'(retry_r);

endmodule

// File: doc/frigate_xo_sequencer.md
# frigate_xo_sequencer

Digital start-up and supervision controller for one crystal oscillator in the timing subsystem, one instance per LSXO or HSXO. It drives the oscillator's `ena`/`standby` controls, sequences start-up, and qualifies the returned `dout` by counting its edges on the always-on RC-oscillator clock. It declares the clock good, supervises it continuously, and retries or flags failure. It sits in the 1.8 V digital domain between the clock-control registers and the analog timing frontend.

## Interface
- `STARTUP_CYCLES`, default 16384: `clk` cycles spent in START before qualification begins.
- `CHECK_CYCLES`, default 256: length of the qualification window, in `clk` cycles.
- `MIN_EDGES`, default 8: minimum `xo_dout` rising edges inside the window for a pass.
- `TIMEOUT_CYCLES`, default 64: maximum gap between `xo_dout` rising edges while in RUN.
- `MAX_RETRIES`, default 3: number of failed qualifications allowed before FAIL.
- `clk`  in  1  always-on reference clock (RC oscillator); the only clock.
- `reset`  in  1  synchronous, active-high.
- `req_on`  in  1  software request to run the oscillator (level).
- `sleep_req`  in  1  request to park a running oscillator in standby (level).
- `xo_dout`  in  1  oscillator output, asynchronous to `clk`; frequency ≤ clk/4 (pre-divided when required).
- `xo_ena`  out  1  oscillator enable.
- `xo_standby`  out  1  oscillator standby.
- `clk_ok`  out  1  oscillator qualified and running.
- `fail`  out  1  retries exhausted; sticky until `req_on`=0.
- `state`  out  3  current state encoding, for status readback.
- `retry_cnt`  out  2  failed qualifications since the last OFF or pass; saturates at MAX_RETRIES.

## Operation
- The input path is a 2-flop synchronizer on `xo_dout` plus a history flop. `edge` = sync & ~hist.
- States and encodings: OFF=0, START=1, CHECK=2, RUN=3, STBY=4, FAIL=5. Encodings 6 and 7 return to OFF.
- OFF: `xo_ena`=0, `xo_standby`=0. All counters are cleared, `retry_cnt` included. `req_on`=1 moves to START.
- START: `xo_ena`=1. The cycle counter runs 0..STARTUP_CYCLES-1, then the state moves to CHECK.
- CHECK: `xo_ena`=1. The window counter runs CHECK_CYCLES cycles. The edge counter increments on each `edge` and saturates at MIN_EDGES.
  - Window end with edges ≥ MIN_EDGES: go to RUN and clear `retry_cnt`.
  - Window end with edges < MIN_EDGES: increment `retry_cnt`. If the new value is ≤ MAX_RETRIES-1, go to START and restart the counter; `xo_ena` stays 1. Otherwise go to FAIL.
- RUN: `clk_ok`=1. The watchdog loads TIMEOUT_CYCLES on entry and on every `edge`, and decrements otherwise.
  - Watchdog reaching 0: treated as a failed qualification (same retry rule) and the state goes to CHECK.
  - `sleep_req`=1: go to STBY.
- STBY: `xo_ena`=1, `xo_standby`=1, `clk_ok`=0, watchdog idle. `sleep_req`=0 moves to CHECK for a full requalification.
- FAIL: `xo_ena`=0, `fail`=1. The state holds until `req_on`=0, then moves to OFF.
- Priorities, highest first:
  - `req_on`=0 forces OFF from any state.
  - `sleep_req` beats a watchdog timeout in the same cycle.
  - `edge` beats watchdog expiry in the same cycle (the counter reloads).
- `sleep_req` is ignored in every state other than RUN and STBY.
- Counter widths are $clog2(param+1). Counters never wrap.

## Timing
- Reset: state=OFF. `xo_ena`, `xo_standby`, `clk_ok`, `fail` are all 0. `state`=0, `retry_cnt`=0, synchronizer and history flops are 0.
- All outputs are registered, decoded from the next state, so they change in the same edge as `state`.
- `req_on` sampled high at edge N → `state`=START and `xo_ena`=1 after edge N. CHECK is entered STARTUP_CYCLES cycles later.
- `xo_dout` rising → `edge` is seen 3 `clk` edges later (2 sync + 1 history).
- CHECK lasts exactly CHECK_CYCLES cycles. `clk_ok` rises on the edge that ends the window.
- After the last `edge` in RUN, `clk_ok` falls TIMEOUT_CYCLES+1 cycles later, absent further edges.
- `req_on` deasserted mid-sequence → OFF next edge. All outputs are 0, and a fresh START follows on re-request.

## Test plan
Parameters for all scenarios: STARTUP=32, CHECK=64, MIN_EDGES=4, TIMEOUT=16, MAX_RETRIES=2.
- Clean start: `req_on`=1 with `xo_dout` toggling every 4 clk → `xo_ena`=1 at cycle 1, CHECK at cycle 33, `clk_ok`=1 at cycle 97, `retry_cnt`=0.
- Dead crystal: `req_on`=1, `xo_dout`=0 → `retry_cnt` goes 1 and then FAIL. `fail`=1 and `xo_ena`=0 at cycle 193. Dropping `req_on` → OFF, `fail`=0.
- Clock loss: in RUN, stop `xo_dout` → `clk_ok`=0 17 cycles after the last edge, state=CHECK, `retry_cnt`=1. Restarting toggles → RUN, `retry_cnt`=0.
- Standby: in RUN, `sleep_req`=1 → STBY, `xo_standby`=1, `clk_ok`=0. Release → CHECK, then RUN 64 cycles later.
- Abort: `req_on`=0 mid-CHECK → OFF next cycle with all outputs 0. Re-request → START with counters restarted.
- Corners:
  - Watchdog expiry and `sleep_req` in the same cycle → STBY with `retry_cnt` unchanged.
  - `edge` on the expiry cycle → stays in RUN.
  - `reset` mid-RUN → all outputs 0 next cycle.
